// File: rtl/act_pkg.sv
// Shared types, default widths and saturating fixed-point helpers for the
// vector activation unit.
package act_pkg;

  localparam int INT_WIDTH_DEF  = 6;
  localparam int FRAC_WIDTH_DEF = 10;
  localparam int NUM_WIDTH      = INT_WIDTH_DEF + FRAC_WIDTH_DEF;
  localparam logic signed [NUM_WIDTH-1:0] ONE = NUM_WIDTH'(1 << FRAC_WIDTH_DEF);

  typedef enum logic [1:0] {
    MODE_RELU         = 2'd0,
    MODE_RELU_DIFF    = 2'd1,
    MODE_SOFTMAX      = 2'd2,
    MODE_SOFTMAX_DIFF = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SUM,
    ST_INV,
    ST_OUT
  } state_t;

  // Wide container so the helpers work for any configured width up to 32 bits.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_wide(input wide_t v, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w);
    return sat_wide(a + b, w);
  endfunction

  function automatic wide_t sat_sub(input wide_t a, input wide_t b, input int w);
    return sat_wide(a - b, w);
  endfunction

  function automatic wide_t sat_mul(input wide_t a, input wide_t b, input int frac, input int w);
    return sat_wide((a * b) >>> frac, w);
  endfunction

  function automatic wide_t sat_uadd(input wide_t a, input wide_t b, input int w);
    wide_t v;
    wide_t hi;
    v  = a + b;
    hi = (wide_t'(1) <<< w) - wide_t'(1);
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/recip_pwl.sv
// Combinational piecewise-linear reciprocal of an unsigned fixed-point value:
// normalise to [1,2), evaluate one of four line segments, shift back.
module recip_pwl #(
  parameter int INT_WIDTH  = 6,
  parameter int FRAC_WIDTH = 10
) (
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] den,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] recip
);

  localparam int NW = INT_WIDTH + FRAC_WIDTH;
  localparam int WW = NW + 16;
  localparam logic [WW-1:0] MAX_POS = {{(WW-NW+1){1'b0}}, {(NW-1){1'b1}}};

  int lead;
  logic [WW-1:0] den_w;
  logic [WW-1:0] m_q;
  logic [WW-1:0] coef_a;
  logic [WW-1:0] coef_b;
  logic [WW-1:0] num;
  logic [WW-1:0] y_q;
  logic [WW-1:0] y_sh;

  // Coefficients are held in units of 1/128 so the segment result is
  // (a*2^F - b*m) >> 7 with m already in Q.F.
  always_comb begin
    lead = 0;
    for (int b = 0; b < NW; b++) begin
      if (den[b]) lead = b;
    end
    den_w = WW'(den);
    if (lead >= FRAC_WIDTH) m_q = den_w >> (lead - FRAC_WIDTH);
    else                    m_q = den_w << (FRAC_WIDTH - lead);
    case (m_q[FRAC_WIDTH-1 -: 2])
      2'b00:   begin coef_a = WW'(230); coef_b = WW'(102); end
      2'b01:   begin coef_a = WW'(190); coef_b = WW'(70);  end
      2'b10:   begin coef_a = WW'(157); coef_b = WW'(48);  end
      default: begin coef_a = WW'(136); coef_b = WW'(36);  end
    endcase
    num = (coef_a << FRAC_WIDTH) - coef_b * m_q;
    y_q = num >> 7;
    if (lead >= FRAC_WIDTH) y_sh = y_q >> (lead - FRAC_WIDTH);
    else                    y_sh = y_q << (FRAC_WIDTH - lead);
    if (den == '0 || y_sh > MAX_POS) recip = MAX_POS[NW-1:0];
    else                             recip = y_sh[NW-1:0];
  end

endmodule

// File: rtl/act_vec_seq.sv
// Streamed vector activation unit: leaky ReLU, its derivative, approximate
// softmax and (with ACT_SOFTMAX_DIFF_EN defined) softmax derivative.
module act_vec_seq
  import act_pkg::*;
#(
  parameter int INT_WIDTH  = INT_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int LEAK_SHIFT = 3,
  parameter int VEC_LEN    = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [1:0]                           mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] out_data,
  output logic                                 out_last,
  output logic                                 busy
);

  localparam int NW = INT_WIDTH + FRAC_WIDTH;
  localparam int IW = $clog2(VEC_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
  localparam logic signed [NW-1:0] ONE_Q = NW'(1 << FRAC_WIDTH);
  localparam logic signed [NW-1:0] MIN_FLOOR = NW'(-FRAC_WIDTH);

  state_t state;
  mode_t  mode_r;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel_idx;
  logic signed [NW-1:0] buffer [VEC_LEN];
  logic signed [NW-1:0] max_r;
  logic signed [NW-1:0] max_next;
  logic [NW-1:0] sum_r;
  logic [NW-1:0] sum_next;
  logic [NW-1:0] inv_r;
  logic [NW-1:0] inv_sel;
  logic [NW-1:0] recip_out;
  logic signed [NW-1:0] diff_q;
  logic signed [NW-1:0] floor_q;
  logic signed [NW-1:0] exp_val;
  logic signed [NW-1:0] sel_elem;
  logic signed [NW-1:0] soft_q;
  logic signed [NW-1:0] calc_res;

  assign in_ready = (state == ST_LOAD);
  assign busy     = (state != ST_LOAD) || (idx != '0);
  assign max_next = (idx == '0 || in_data > max_r) ? in_data : max_r;

  recip_pwl #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_recip (
    .den   (sum_r),
    .recip (recip_out)
  );

  // Power-of-two exponent: 2^floor(x - max), flushed to zero below one LSB.
  always_comb begin
    diff_q  = NW'(sat_sub(wide_t'(buffer[idx]), wide_t'(max_r), NW));
    floor_q = diff_q >>> FRAC_WIDTH;
    exp_val = '0;
    if (floor_q >= MIN_FLOOR) exp_val = ONE_Q >>> (-floor_q);
    sum_next = NW'(sat_uadd(wide_t'(sum_r), wide_t'(exp_val), NW));
  end

  always_comb begin
    sel_idx = '0;
    if (state == ST_OUT && idx != LAST_IDX) sel_idx = idx + IW'(1);
  end

  // Result for the element about to be presented; during INV the fresh
  // reciprocal is used directly so element 0 is ready on entry to OUT.
  always_comb begin
    sel_elem = buffer[sel_idx];
    inv_sel  = (state == ST_INV) ? recip_out : inv_r;
    soft_q   = NW'(sat_mul(wide_t'(sel_elem), wide_t'(inv_sel), FRAC_WIDTH, NW));
    calc_res = soft_q;
    case (mode_r)
      MODE_RELU:      calc_res = sel_elem[NW-1] ? (sel_elem >>> LEAK_SHIFT) : sel_elem;
      MODE_RELU_DIFF: calc_res = sel_elem[NW-1] ? (ONE_Q >>> LEAK_SHIFT) : ONE_Q;
`ifdef ACT_SOFTMAX_DIFF_EN
      MODE_SOFTMAX_DIFF:
        calc_res = NW'(sat_sub(wide_t'(soft_q),
                               sat_mul(wide_t'(soft_q), wide_t'(soft_q), FRAC_WIDTH, NW), NW));
`endif
      default:        calc_res = soft_q;
    endcase
  end

  // Element storage: raw inputs during LOAD, replaced by exponentials in SUM.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && in_valid)
      buffer[idx] <= in_data;
    else if (state == ST_SUM)
      buffer[idx] <= exp_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      idx       <= '0;
      mode_r    <= MODE_RELU;
      max_r     <= '0;
      sum_r     <= '0;
      inv_r     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            max_r <= max_next;
            if (idx == '0) mode_r <= mode_t'(mode);
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (mode_r == MODE_SOFTMAX || mode_r == MODE_SOFTMAX_DIFF) begin
                state <= ST_SUM;
                sum_r <= '0;
              end else begin
                state     <= ST_OUT;
                out_valid <= 1'b1;
                out_data  <= calc_res;
                out_last  <= 1'b0;
              end
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        ST_SUM: begin
          sum_r <= sum_next;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= ST_INV;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_INV: begin
          inv_r     <= recip_out;
          state     <= ST_OUT;
          out_valid <= 1'b1;
          out_data  <= calc_res;
          out_last  <= 1'b0;
        end
        default: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state     <= ST_LOAD;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= sel_idx;
              out_data <= calc_res;
              out_last <= (sel_idx == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_vec_seq.sv
// Directed table-driven bench for act_vec_seq (VEC_LEN=4, Q6.10), plus
// stall and mid-SUM reset sequences.
module tb_act_vec_seq;
  import act_pkg::*;

  localparam int VL = 4;
  localparam int NW = NUM_WIDTH;
  localparam int LAT_RELU = 1;
  localparam int LAT_SOFT = VL + 2;
`ifdef ACT_SOFTMAX_DIFF_EN
  localparam int SD_ZERO = 192;
`else
  localparam int SD_ZERO = 256;
`endif

  typedef struct packed {
    logic [1:0]            mode;
    logic [VL-1:0][NW-1:0] din;
    logic [VL-1:0][NW-1:0] dout;
    logic [7:0]            lat;
    logic [1:0]            tol;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] mode;
  logic in_valid;
  logic in_ready;
  logic signed [NW-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [NW-1:0] out_data;
  logic out_last;
  logic busy;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs [8];

  always #5 clk = ~clk;

  act_vec_seq #(
    .VEC_LEN (VL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [VL-1:0][NW-1:0] q4(input int a, input int b, input int c, input int d);
    logic [VL-1:0][NW-1:0] r;
    r[0] = NW'(a);
    r[1] = NW'(b);
    r[2] = NW'(c);
    r[3] = NW'(d);
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] m, input logic [VL-1:0][NW-1:0] din,
                              input logic [VL-1:0][NW-1:0] dout, input int lat, input int tol);
    vec_t v;
    v.mode = m;
    v.din  = din;
    v.dout = dout;
    v.lat  = 8'(lat);
    v.tol  = 2'(tol);
    return v;
  endfunction

  task automatic check_output(input string name, input int idx, input int actual,
                              input int expected, input int tol);
    n_vec++;
    if (actual > expected + tol || actual < expected - tol) begin
      n_err++;
      $display("[TB] FAIL %s[%0d]: actual %0d (0x%0h), required %0d (+/-%0d)",
               name, idx, actual, actual, expected, tol);
    end
  endtask

  // Later beats carry the inverted mode; the unit must keep the first one.
  task automatic send_vector(input logic [1:0] m, input logic [VL-1:0][NW-1:0] din);
    for (int i = 0; i < VL; i++) begin
      @(negedge clk);
      mode     = (i == 0) ? m : ~m;
      in_data  = din[i];
      in_valid = 1'b1;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int vid);
    int lat;
    out_ready = 1'b1;
    send_vector(v.mode, v.din);
    wait_valid(lat);
    check_output("latency", vid, lat, int'(v.lat), 0);
    for (int j = 0; j < VL; j++) begin
      check_output("valid", vid * 10 + j, int'(out_valid), 1, 0);
      check_output("data", vid * 10 + j, int'(out_data), int'($signed(v.dout[j])), int'(v.tol));
      check_output("last", vid * 10 + j, int'(out_last), (j == VL - 1) ? 1 : 0, 0);
      @(negedge clk);
    end
    check_output("drained", vid, int'(out_valid), 0, 0);
    check_output("ready_after", vid, int'(in_ready), 1, 0);
  endtask

  task automatic stall_sequence();
    int lat;
    int j;
    int cyc;
    out_ready = 1'b0;
    send_vector(vecs[0].mode, vecs[0].din);
    wait_valid(lat);
    check_output("stall_latency", 0, lat, LAT_RELU, 0);
    j = 0;
    cyc = 0;
    while (j < VL && cyc < 40) begin
      check_output("stall_valid", cyc, int'(out_valid), 1, 0);
      check_output("stall_data", cyc, int'(out_data), int'($signed(vecs[0].dout[j])), 0);
      check_output("stall_last", cyc, int'(out_last), (j == VL - 1) ? 1 : 0, 0);
      out_ready = (cyc % 2 == 1);
      @(posedge clk);
      if (out_ready) j++;
      @(negedge clk);
      cyc++;
    end
    check_output("stall_count", 0, j, VL, 0);
    check_output("stall_drained", 0, int'(out_valid), 0, 0);
    out_ready = 1'b1;
  endtask

  task automatic reset_sequence();
    int saw;
    out_ready = 1'b1;
    send_vector(2'd2, vecs[2].din);
    @(negedge clk);
    @(negedge clk);
    check_output("sum_busy", 0, int'(busy), 1, 0);
    check_output("sum_in_ready", 0, int'(in_ready), 0, 0);
    rst = 1'b1;
    #1;
    check_output("rst_in_ready", 0, int'(in_ready), 1, 0);
    check_output("rst_out_valid", 0, int'(out_valid), 0, 0);
    check_output("rst_busy", 0, int'(busy), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check_output("rst_no_output", 0, saw, 0, 0);
    check_output("rst_ready_idle", 0, int'(in_ready), 1, 0);
    apply_stimulus(vecs[3], 9);
  endtask

  initial begin
    rst       = 1'b1;
    mode      = 2'd0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Hand-computed expectations in Q6.10 (1.0 = 1024).
    vecs[0] = mk(2'd0, q4(1024, -1024, 0, -8192), q4(1024, -128, 0, -1024), LAT_RELU, 0);
    vecs[1] = mk(2'd1, q4(2048, -512, 0, -3072), q4(1024, 128, 1024, 128), LAT_RELU, 0);
    vecs[2] = mk(2'd2, q4(0, 0, 0, 0), q4(256, 256, 256, 256), LAT_SOFT, 0);
    vecs[3] = mk(2'd2, q4(3072, 0, 0, 0), q4(750, 93, 93, 93), LAT_SOFT, 1);
    vecs[4] = mk(2'd3, q4(0, 0, 0, 0), q4(SD_ZERO, SD_ZERO, SD_ZERO, SD_ZERO), LAT_SOFT, 0);
    vecs[5] = mk(2'd0, q4(32767, -32768, -1, 8), q4(32767, -4096, -1, 8), LAT_RELU, 0);
    vecs[6] = mk(2'd2, q4(-32768, 32767, 0, 0), q4(0, int'(ONE), 0, 0), LAT_SOFT, 0);
    vecs[7] = mk(2'd2, q4(0, -10240, -11264, 0), q4(512, 0, 0, 512), LAT_SOFT, 0);

    repeat (2) @(negedge clk);
    check_output("reset_in_ready", 0, int'(in_ready), 1, 0);
    check_output("reset_out_valid", 0, int'(out_valid), 0, 0);
    check_output("reset_out_data", 0, int'(out_data), 0, 0);
    check_output("reset_out_last", 0, int'(out_last), 0, 0);
    check_output("reset_busy", 0, int'(busy), 0, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], i);
    stall_sequence();
    reset_sequence();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/act_vec_seq.md
# act_vec_seq

Sequential, parametrised activation unit that applies one of four vector activations to a streamed vector of VEC_LEN fixed-point values: leaky ReLU, leaky ReLU derivative, approximate softmax, and softmax derivative. It sits between the output layer accumulators and the loss/backprop path. It replaces per-channel combinational activation logic with one shared exp/reciprocal/multiply datapath time-multiplexed over channels. Input and output are valid/ready streams.

## Interface
- INT_WIDTH, 6: integer bits incl. sign
- FRAC_WIDTH, 10: fraction bits (≥7)
- LEAK_SHIFT, 3: leaky slope 2^-LEAK_SHIFT
- VEC_LEN, 10: elements per vector (≥2)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  0 relu, 1 relu_diff, 2 softmax, 3 softmax_diff; sampled with first input beat
- in_valid  in  1  input beat valid
- in_ready  out  1  unit accepts input
- in_data  in  NUM_WIDTH  signed Q(INT,FRAC) element; NUM_WIDTH = INT_WIDTH+FRAC_WIDTH
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output
- out_data  out  NUM_WIDTH  result element
- out_last  out  1  marks element VEC_LEN-1
- busy  out  1  vector in flight (LOAD with ≥1 beat, SUM, INV, OUT)

## Operation
- Reset: state LOAD, index 0, in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, max/sum/inv registers 0.
- States: LOAD → (mode≥2) SUM → INV → OUT → LOAD; (mode<2) LOAD → OUT → LOAD.
- LOAD: in_ready=1; each handshake writes buffer[idx] and updates running signed max; the beat with idx=VEC_LEN-1 leaves LOAD. Mode latched on idx=0 beat; later mode changes ignored.
- SUM (VEC_LEN cycles, one element per cycle): d = sat(x−max) (≤0); e = 2^floor(d) when floor(d) ≥ −FRAC_WIDTH, else 0; e overwrites buffer[i]; sum += e (saturating, unsigned NUM_WIDTH).
- INV (1 cycle): inv = recip(sum). sum ∈ [1, VEC_LEN]. Normalise to m ∈ [1,2) by leading-one position; segments on m: [1,1.25) 115/64−51/64·m; [1.25,1.5) 95/64−35/64·m; [1.5,1.75) 157/128−3/8·m; [1.75,2) 17/16−9/32·m; shift back by the same exponent; truncate to FRAC_WIDTH.
- OUT: out_data per element i: relu x≥0 ? x : x>>>LEAK_SHIFT; relu_diff x<0 ? 2^-LEAK_SHIFT : 1.0; softmax s=sat(e·inv); softmax_diff sat(s−s·s). Products truncate to FRAC_WIDTH, saturate to signed range.
- out_data held stable while out_valid && !out_ready. Index advances only on handshake. After last handshake: LOAD, idx 0.
- in_ready=0 outside LOAD; no input consumed outside LOAD.

## Timing
- Input beat accepted on any edge with in_valid&&in_ready; back-to-back beats allowed.
- Last input at edge k: relu modes out_valid from cycle k+1; softmax modes SUM cycles k+1..k+VEC_LEN, INV k+VEC_LEN+1, out_valid from k+VEC_LEN+2.
- OUT with out_ready=1: one element per cycle; next vector's first input accepted cycle after last output handshake (no overlap).
- rst mid-operation (any state): immediate return to reset values; partial vector discarded, no output beat produced.

## Configuration
- ACT_SOFTMAX_DIFF_EN defined: mode 3 implemented as above (extra squarer + subtractor).
- Undefined: squarer/subtractor not built; mode 3 behaves exactly as mode 2.

## Structure
- Package act_pkg: NUM_WIDTH, mode enum (MODE_RELU, MODE_RELU_DIFF, MODE_SOFTMAX, MODE_SOFTMAX_DIFF), state enum, fixed-point ONE constant, saturating add/sub/mul functions.
- One sub-module: recip_pwl (combinational piecewise-linear reciprocal, NUM_WIDTH in/out), instantiated once in INV.

## Test plan
- Relu, VEC_LEN=4, in {1.0, −1.0, 0, −8.0} → out {1.0, −0.125, 0, −1.0}; out_valid cycle after last input.
- Relu_diff, in {2.0, −0.5, 0, −3.0} → {1.0, 0.125, 1.0, 0.125}.
- Softmax, VEC_LEN=4, all inputs 0 → sum 4.0, inv 0.25, each output 0x100 (0.25); first out_valid at k+VEC_LEN+2.
- Softmax, in {3.0, 0, 0, 0} → exps {1, 0.125×3}, sum 1.375, out {0x2EE, 0x05D, 0x05D, 0x05D} ±1 LSB.
- Softmax_diff (macro on), all inputs 0 → each 0x0C0 (0.1875); macro off → each 0x100.
- out_ready toggled 1/0 each cycle during OUT → each value held while stalled, no drops; rst asserted mid-SUM → out_valid never rises, in_ready=1 next cycle, following vector correct.
